// File: rtl/aes_serial_loader_pkg.sv
// Shared definitions for the AES serial loader: block width, bit-counter width
// and the loader FSM state encoding.
package aes_serial_loader_pkg;
   localparam int BLOCK_W = 128;
   localparam int CNT_W   = 7;
   localparam logic [CNT_W-1:0] CNT_LAST = 7'd127;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_KEY  = 2'd1,
      S_DATA = 2'd2,
      S_HOLD = 2'd3
   } state_t;
endpackage

// File: rtl/aes_shift_field.sv
// 128-bit field assembled one bit at a time: when enabled, the incoming bit is
// written at the given index and all other bits keep their value.
module aes_shift_field
   import aes_serial_loader_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [CNT_W-1:0]   idx,
   input  logic               bit_in,
   output logic [BLOCK_W-1:0] field
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     field      <= '0;
      else if (en) field[idx] <= bit_in;
   end

endmodule

// File: rtl/aes_serial_loader.sv
// Serial-to-parallel loader for an AES core: collects an optional 128-bit key
// and a 128-bit block LSB-first, then holds them until the cipher accepts.
module aes_serial_loader
   import aes_serial_loader_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_bit,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               load_key,
   input  logic               mode_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BLOCK_W-1:0] out_key,
   output logic [BLOCK_W-1:0] out_data,
   output logic               out_mode,
   output logic               key_loaded
);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] count;
   logic             xfer;
   logic             eff_key;
   logic             key_en, data_en;

   assign in_ready  = (state != S_HOLD);
   assign out_valid = (state == S_HOLD);
   assign xfer      = in_valid & in_ready;
   // With no key ever loaded, a data-only request still has to build a key first.
   assign eff_key   = load_key | ~key_loaded;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      key_en    = 1'b0;
      data_en   = 1'b0;
      unique case (state)
         S_IDLE: if (xfer) begin
            key_en    = eff_key;
            data_en   = ~eff_key;
            state_nxt = eff_key ? S_KEY : S_DATA;
         end
         S_KEY: if (xfer) begin
            key_en = 1'b1;
            if (count == CNT_LAST) state_nxt = S_DATA;
         end
         S_DATA: if (xfer) begin
            data_en = 1'b1;
            if (count == CNT_LAST) state_nxt = S_HOLD;
         end
         S_HOLD: if (out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Count is 0 in S_IDLE, so a plain increment covers frame start and the 127->0 wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count      <= '0;
         key_loaded <= 1'b0;
         out_mode   <= 1'b0;
      end else if (xfer) begin
         count <= count + 1'b1;
         if (state == S_IDLE) out_mode <= mode_in;
         if (state == S_KEY && count == CNT_LAST) key_loaded <= 1'b1;
      end
   end

   aes_shift_field u_key (
      .clk    (clk),
      .rst    (rst),
      .en     (key_en),
      .idx    (count),
      .bit_in (in_bit),
      .field  (out_key)
   );

   aes_shift_field u_data (
      .clk    (clk),
      .rst    (rst),
      .en     (data_en),
      .idx    (count),
      .bit_in (in_bit),
      .field  (out_data)
   );

endmodule

// File: doc/aes_serial_loader.md
AES_SERIAL_LOADER -- requirements
Module: aes_serial_loader

Interface
REQ-001 The block SHALL have no parameters; block width is fixed at 128 bits.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_bit  input  1  serial data bit.
REQ-005 in_valid  input  1  in_bit is valid this cycle.
REQ-006 in_ready  output  1  loader accepts in_bit this cycle.
REQ-007 load_key  input  1  sampled with the first bit of a frame: 1 = 256-bit frame (key then data), 0 = 128-bit data-only frame.
REQ-008 mode_in  input  1  encrypt(1)/decrypt(0) select, sampled with the first bit of a frame.
REQ-009 out_valid  output  1  out_key/out_data/out_mode hold a complete block.
REQ-010 out_ready  input  1  downstream cipher stage accepts the block.
REQ-011 out_key  output  128  assembled key.
REQ-012 out_data  output  128  assembled plaintext/ciphertext block.
REQ-013 out_mode  output  1  mode latched for this block.
REQ-014 key_loaded  output  1  a key has been loaded since reset.

Function
REQ-015 A transfer SHALL occur when in_valid and in_ready are both 1 on a rising edge.
REQ-016 Bit n of a 128-bit field (n = 0..127, first received = 0) SHALL land at field bit n, so byte 0 = bits 7:0, matching the column-major state layout.
REQ-017 States SHALL be S_IDLE, S_KEY, S_DATA, S_HOLD.
REQ-018 In S_IDLE, a transfer SHALL latch mode_in and load_key and store the bit at index 0. Next state: S_KEY if load_key = 1, else S_DATA. The count SHALL become 1.
REQ-019 S_KEY SHALL write out_key[count]. On the transfer with count = 127 it SHALL wrap count to 0 and go to S_DATA.
REQ-020 S_DATA SHALL write out_data[count]. On the transfer with count = 127 it SHALL go to S_HOLD and assert out_valid on the next cycle.
REQ-021 The counter SHALL be 7 bits, SHALL increment only on a transfer, and SHALL wrap 127 -> 0.
REQ-022 in_ready SHALL be 1 in S_IDLE, S_KEY and S_DATA, and 0 in S_HOLD.
REQ-023 In S_IDLE, load_key = 0 while key_loaded = 0 SHALL be treated as load_key = 1.
REQ-024 out_valid SHALL be 1 exactly in S_HOLD. out_key, out_data and out_mode SHALL stay stable while out_valid = 1.
REQ-025 In S_HOLD, out_ready = 1 SHALL return the block to S_IDLE on that edge. If out_ready stays 0, the block SHALL hold indefinitely and ignore in_valid.
REQ-026 A data-only frame SHALL leave out_key unchanged, so the previous key is reused.
REQ-027 in_valid deasserted mid-frame SHALL pause the block with no state or count change. There is no timeout.
REQ-028 key_loaded SHALL set on completion of an S_KEY field and SHALL stay set until reset.
REQ-029 Latency: the last data bit transfer at edge N SHALL give out_valid = 1 after edge N. Back-to-back frames SHALL allow in_ready = 1 on the edge after the out_ready handshake.

Reset
REQ-030 rst SHALL immediately force S_IDLE, count = 0, out_valid = 0, key_loaded = 0, out_key = 0, out_data = 0 and out_mode = 0, asynchronously to clk.
REQ-031 rst asserted mid-frame or in S_HOLD SHALL discard the partial or held block. The first transfer after deassertion SHALL start a new frame.
REQ-032 in_ready SHALL be 1 combinationally in S_IDLE after reset.

Structure
REQ-033 The shared AES package SHALL hold the state encoding, the BLOCK_W = 128 constant and the count width (7).
REQ-034 The block SHALL be single-level. One optional sub-module, aes_shift_field (128-bit indexed bit writer with enable), MAY be instantiated twice, once for key and once for data.
REQ-035 The out_key, out_data and out_mode outputs SHALL feed aes_encrypt/aes_decrypt directly, with no further registering required.

Verification
REQ-036 Reset, then a 256-bit frame with load_key = 1, key = 128'h000102...0F and data = 128'h00112233445566778899AABBCCDDEEFF, out_ready = 1 -> out_valid pulses for 1 cycle with exact fields and key_loaded = 1.
REQ-037 After REQ-036, a data-only frame with data = all-ones -> out_key unchanged, out_data = 128'hFF..FF, and exactly 128 transfers are counted.
REQ-038 Reset, then a frame with load_key = 0 -> treated as a key frame: the first 128 bits go to out_key.
REQ-039 Hold out_ready = 0 for 20 cycles after completion while toggling in_valid -> in_ready = 0, outputs stable; then out_ready = 1 -> S_IDLE on the next edge.
REQ-040 Random in_valid gaps (50% duty) during a frame -> result identical to the gap-free run.
REQ-041 Assert rst at bit 200 of a key frame -> outputs zero immediately; a fresh full frame then completes correctly.
